// File: rtl/wpa2_pio_pkg.sv
// Shared constants for the WPA2 cracker PIO blocks: register map and edge-type encodings.
package wpa2_pio_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/wpa2_pio_status_if.sv
// Avalon-MM slave register bus plus interrupt line for the status PIO.
interface wpa2_pio_status_if;
    import wpa2_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;
    logic              irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/wpa2_sync_bus.sv
// WIDTH-wide multi-flop synchronizer with synchronous reset; the last stage is the output.
module wpa2_sync_bus #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/wpa2_pio_status.sv
// Input PIO: synchronizes the cracker status bus, captures per-bit edges into a
// sticky W1C register and raises a maskable level interrupt to the Nios CPU.
module wpa2_pio_status
    import wpa2_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISING,
    parameter int unsigned MASK_RESET  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_port,
    wpa2_pio_status_if.slave   bus
);

    localparam logic [WIDTH-1:0] MASK_INIT = WIDTH'(MASK_RESET);

    logic [WIDTH-1:0] w_data_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edge_next;
    logic [BUS_W-1:0] w_rd_mux;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_data_d;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [BUS_W-1:0] r_readdata;

    wpa2_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (in_port),
        .o_q   (w_data_in)
    );

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign w_edge = ~w_data_in & r_data_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign w_edge = w_data_in ^ r_data_d;
        end else begin : g_rise
            assign w_edge = w_data_in & ~r_data_d;
        end
    endgenerate

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_rd           = bus.chipselect & ~bus.read_n;
    assign w_wdata        = bus.writedata[WIDTH-1:0];
    assign w_unused_wdata = ^bus.writedata;

    // New edges override a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        w_clr = '0;
        if (w_wr && (bus.address == ADDR_EDGE)) begin
            w_clr = w_wdata;
        end
        w_edge_next = (r_edge_capture & ~w_clr) | w_edge;
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_DATA: w_rd_mux = BUS_W'(w_data_in);
            ADDR_MASK: w_rd_mux = BUS_W'(r_irq_mask);
            ADDR_EDGE: w_rd_mux = BUS_W'(r_edge_capture);
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_d       <= '0;
            r_edge_capture <= '0;
            r_irq_mask     <= MASK_INIT;
            r_readdata     <= '0;
        end else begin
            r_data_d       <= w_data_in;
            r_edge_capture <= w_edge_next;
            if (w_wr && (bus.address == ADDR_MASK)) begin
                r_irq_mask <= w_wdata;
            end
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_wpa2_pio_status.sv
// Directed bench for wpa2_pio_status: rising-edge instance (dut0) and any-edge instance (dut1).
module tb_wpa2_pio_status;
    import wpa2_pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0;
    logic [7:0] in1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    wpa2_pio_status_if b0 ();
    wpa2_pio_status_if b1 ();

    wpa2_pio_status #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING), .MASK_RESET(0)
    ) dut0 (
        .clk(clk), .reset(reset), .in_port(in0), .bus(b0)
    );

    wpa2_pio_status #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY), .MASK_RESET(0)
    ) dut1 (
        .clk(clk), .reset(reset), .in_port(in1), .bus(b1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        b0.chipselect = 1'b0; b0.read_n = 1'b1; b0.write_n = 1'b1;
        b0.address = 2'd0; b0.writedata = 32'h0;
        b1.chipselect = 1'b0; b1.read_n = 1'b1; b1.write_n = 1'b1;
        b1.address = 2'd0; b1.writedata = 32'h0;
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] wd);
        if (d == 0) begin
            b0.chipselect = 1'b1; b0.write_n = 1'b0; b0.address = a; b0.writedata = wd;
        end else begin
            b1.chipselect = 1'b1; b1.write_n = 1'b0; b1.address = a; b1.writedata = wd;
        end
        tick(1);
        bus_idle();
    endtask

    task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] q);
        if (d == 0) begin
            b0.chipselect = 1'b1; b0.read_n = 1'b0; b0.address = a;
        end else begin
            b1.chipselect = 1'b1; b1.read_n = 1'b0; b1.address = a;
        end
        tick(1);
        q = (d == 0) ? b0.readdata : b1.readdata;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset = 1'b1; in0 = 8'hFF; in1 = 8'h00;
        tick(2);
        checks++;
        if (b0.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want %h", b0.readdata, 32'h0); end
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", b0.irq); end
        reset = 1'b0;
        tick(2);
        bus_read(0, ADDR_DATA, q);
        checks++;
        if (q !== 32'h000000FF) begin errors++; $display("FAIL reset_data_sync: got %h want %h", q, 32'hFF); end
        bus_write(0, ADDR_EDGE, 32'hFF);
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL reset_edge_clear: got %h want %h", q, 32'h0); end
        in0 = 8'h00;
        tick(4);
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL falling_not_captured: got %h want %h", q, 32'h0); end
    endtask

    task automatic test_rising();
        logic [31:0] q;
        bus_write(0, ADDR_MASK, 32'h1);
        in0 = 8'h01;
        tick(1);
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL rise_irq_e0: got %b want 0", b0.irq); end
        tick(1);
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL rise_irq_e1: got %b want 0", b0.irq); end
        tick(1);
        checks++;
        if (b0.irq !== 1'b1) begin errors++; $display("FAIL rise_irq_e2: got %b want 1", b0.irq); end
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h1) begin errors++; $display("FAIL rise_edge_read: got %h want %h", q, 32'h1); end
        bus_write(0, ADDR_EDGE, 32'h1);
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL rise_irq_clear: got %b want 0", b0.irq); end
    endtask

    task automatic test_collision();
        logic [31:0] q;
        in0 = 8'h05;
        tick(2);
        bus_write(0, ADDR_EDGE, 32'h4);
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL collide_edge_wins: got %h want %h", q, 32'h4); end
        bus_write(0, ADDR_EDGE, 32'h4);
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL collide_later_clear: got %h want %h", q, 32'h0); end
    endtask

    task automatic test_masking();
        logic [31:0] q;
        bus_write(0, ADDR_MASK, 32'h0);
        in0 = 8'h00;
        tick(4);
        in0 = 8'hFF;
        tick(4);
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL mask_irq_quiet: got %b want 0", b0.irq); end
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'hFF) begin errors++; $display("FAIL mask_edge_all: got %h want %h", q, 32'hFF); end
        bus_write(0, ADDR_MASK, 32'h80);
        checks++;
        if (b0.irq !== 1'b1) begin errors++; $display("FAIL mask_irq_raise: got %b want 1", b0.irq); end
        bus_read(0, ADDR_MASK, q);
        checks++;
        if (q !== 32'h80) begin errors++; $display("FAIL mask_readback: got %h want %h", q, 32'h80); end
        bus_write(0, ADDR_EDGE, 32'hFF);
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL mask_irq_drop: got %b want 0", b0.irq); end
    endtask

    task automatic test_regs();
        logic [31:0] q;
        bus_write(0, ADDR_DATA, 32'hDEADBEEF);
        bus_read(0, ADDR_DATA, q);
        checks++;
        if (q !== 32'hFF) begin errors++; $display("FAIL regs_data_ro: got %h want %h", q, 32'hFF); end
        bus_write(0, ADDR_RSVD, 32'hDEADBEEF);
        bus_read(0, ADDR_RSVD, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL regs_rsvd: got %h want %h", q, 32'h0); end
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL regs_edge_untouched: got %h want %h", q, 32'h0); end
        bus_read(0, ADDR_MASK, q);
        checks++;
        if (q !== 32'h80) begin errors++; $display("FAIL regs_mask_untouched: got %h want %h", q, 32'h80); end
        bus_write(0, ADDR_MASK, 32'hFFFFFF5A);
        bus_read(0, ADDR_MASK, q);
        checks++;
        if (q !== 32'h5A) begin errors++; $display("FAIL regs_mask_trunc: got %h want %h", q, 32'h5A); end
        // simultaneous read and write of the mask
        b0.chipselect = 1'b1; b0.read_n = 1'b0; b0.write_n = 1'b0;
        b0.address = ADDR_MASK; b0.writedata = 32'h33;
        tick(1);
        bus_idle();
        checks++;
        if (b0.readdata !== 32'h5A) begin errors++; $display("FAIL regs_rw_old: got %h want %h", b0.readdata, 32'h5A); end
        bus_read(0, ADDR_MASK, q);
        checks++;
        if (q !== 32'h33) begin errors++; $display("FAIL regs_rw_new: got %h want %h", q, 32'h33); end
        tick(2);
        checks++;
        if (b0.readdata !== 32'h33) begin errors++; $display("FAIL regs_hold: got %h want %h", b0.readdata, 32'h33); end
        b0.chipselect = 1'b1; b0.read_n = 1'b0; b0.address = ADDR_DATA;
        #2;
        checks++;
        if (b0.readdata !== 32'h33) begin errors++; $display("FAIL regs_lat_before: got %h want %h", b0.readdata, 32'h33); end
        tick(1);
        bus_idle();
        checks++;
        if (b0.readdata !== 32'hFF) begin errors++; $display("FAIL regs_lat_after: got %h want %h", b0.readdata, 32'hFF); end
    endtask

    task automatic test_no_side_effect();
        logic [31:0] q;
        in0 = 8'h7F;
        tick(4);
        in0 = 8'hFF;
        tick(4);
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h80) begin errors++; $display("FAIL read1_edge: got %h want %h", q, 32'h80); end
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h80) begin errors++; $display("FAIL read2_edge: got %h want %h", q, 32'h80); end
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL read_irq_masked: got %b want 0", b0.irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        bus_write(0, ADDR_MASK, 32'hFF);
        checks++;
        if (b0.irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pending: got %b want 1", b0.irq); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (b0.irq !== 1'b0) begin errors++; $display("FAIL mid_irq_lost: got %b want 0", b0.irq); end
        checks++;
        if (b0.readdata !== 32'h0) begin errors++; $display("FAIL mid_readdata: got %h want %h", b0.readdata, 32'h0); end
        bus_read(0, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL mid_edge: got %h want %h", q, 32'h0); end
        bus_read(0, ADDR_MASK, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL mid_mask: got %h want %h", q, 32'h0); end
    endtask

    task automatic test_any_edge();
        logic [31:0] q;
        in1 = 8'h08;
        tick(3);
        bus_read(1, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h08) begin errors++; $display("FAIL any_rise: got %h want %h", q, 32'h08); end
        bus_write(1, ADDR_EDGE, 32'h08);
        bus_read(1, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL any_clear: got %h want %h", q, 32'h0); end
        in1 = 8'h00;
        tick(3);
        bus_read(1, ADDR_EDGE, q);
        checks++;
        if (q !== 32'h08) begin errors++; $display("FAIL any_fall: got %h want %h", q, 32'h08); end
        bus_write(1, ADDR_MASK, 32'h08);
        checks++;
        if (b1.irq !== 1'b1) begin errors++; $display("FAIL any_irq: got %b want 1", b1.irq); end
    endtask

    initial begin
        bus_idle();
        reset = 1'b1;
        in0 = 8'hFF;
        in1 = 8'h00;
        test_reset();
        test_rising();
        test_collision();
        test_masking();
        test_regs();
        test_no_side_effect();
        test_reset_mid();
        test_any_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wpa2_pio_status.md
Name: wpa2_pio_status

Overview:
- Avalon-MM slave input PIO. It is the read-side counterpart of the design's output PIOs.
- Samples a status bus from the cracking datapath (found/done/error flags) into the clock domain, then exposes it to the Nios CPU as a readable data register.
- Captures per-bit edges into a sticky register and raises a maskable level interrupt.

Parameters:
- WIDTH, 8: in_port/data width (1..32).
- SYNC_STAGES, 2: synchronizer flops on in_port (2..3).
- EDGE_TYPE, 0: edge captured. 0 = rising, 1 = falling, 2 = any.
- MASK_RESET, 0: reset value of irq mask register.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous status inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: one clock, synchronous, active-high, as stated above. On reset:
  - all sync flops, data_d, edge_capture = 0.
  - irq_mask = MASK_RESET.
  - readdata = 0; irq = 0.
- Synchronizer:
  - in_port passes through SYNC_STAGES flops; the last stage is data_in.
  - data_d = data_in delayed by one clock.
- Edge detect (combinational):
  - rising: data_in & ~data_d.
  - falling: ~data_in & data_d.
  - any: data_in ^ data_d.
- Register map (bits above WIDTH read 0, ignored on write):
  - addr 0: data_in. Read-only; writes ignored.
  - addr 1: irq_mask. R/W.
  - addr 2: reserved. Reads 0; writes ignored.
  - addr 3: edge_capture. Read; write-1-to-clear per bit.
- Write: takes effect when chipselect & ~write_n, at the rising clk edge.
- Edge capture:
  - bit set when edge detected; stays set until cleared.
  - Same cycle as a W1C of that bit: the edge wins, and the bit remains 1.
  - Bits written 0 are unaffected.
- Read:
  - readdata registered. Updated when chipselect & ~read_n, with mux(address) zero-extended to 32.
  - Read latency is 1 cycle.
  - readdata holds its value otherwise.
  - A read has no side effects: it does not clear capture.
- irq: combinational OR-reduce of (edge_capture & irq_mask).
- Latency, SYNC_STAGES=2: a change of in_port set up before clk edge E0 gives:
  - data_in valid after E1.
  - edge_capture set and irq (if masked in) high after E2.
- Read/write at the same address in the same cycle: the write takes effect and the read returns the pre-write value.
- Reset mid-operation: all state returns to reset values on the next edge. Pending interrupts are lost.

Decomposition:
- Shared package wpa2_pio_pkg:
  - register address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=3.
  - EDGE_RISING/FALLING/ANY encodings.
- Natural sub-module: wpa2_sync_bus, a WIDTH-wide multi-flop synchronizer with SYNC_STAGES parameter and synchronous reset. It is reusable by other PIO inputs.

Test Plan:
1. Reset: assert reset 2 cycles, in_port=8'hFF.
   - During reset: readdata=0, irq=0.
   - After release: reading addr 0 returns 32'h000000FF once in_port has passed the synchronizer (2 cycles).
2. Rising capture: mask=8'h01, in_port 0→8'h01.
   - irq high exactly 2 clocks after the change.
   - Read addr 3 = 32'h1.
   - Write addr 3 with 32'h1: irq low next cycle.
3. Clear/edge collision: edge on bit 2 in the same cycle as a W1C of 32'h4 at addr 3. Bit 2 remains set and reads 32'h4.
4. Masking: mask=0, edges on bits 0..7.
   - irq stays 0; edge register reads 32'hFF.
   - Writing mask=8'h80 raises irq next cycle.
5. Register access:
   - Write addr 0 and addr 2 with 32'hDEADBEEF: no state change, and addr 2 reads 0.
   - Mask readback after writing 32'hFFFFFF5A returns 32'h5A.
   - readdata valid 1 cycle after read.
6. EDGE_TYPE=2: toggle bit 3 up then down, clearing in between. Each transition sets capture bit 3.
